bus_arbiter_mux: RTL and testbench

Parametrised, registered successor to the processor's combinational bus multiplexer. Arbitrates among NUM_SRC request lines, using fixed priority or round-robin, and drives the winning source's data onto a registered shared bus. Reports which source won and flags cycles with more than one request. Sits between the register file / ALU / DIN sources and the datapath bus consumers. The control FSM raises requests instead of hand-guaranteeing one-hot selects.

---
 rtl/bus_arbiter_mux_if.sv | 29 ++
 rtl/bus_arbiter_mux.sv | 105 ++++++++++
 tb/tb_bus_arbiter_mux.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_mux_if.sv
// Shared-bus arbiter signal bundle: source data and requests in, grant/bus/status out.
// The master side drives sources and hold; the slave side is the arbiter.
interface bus_arbiter_mux_if #(
  parameter int REG_WIDTH = 16,
  parameter int NUM_SRC   = 10,
  parameter int CNT_WIDTH = 8
);
  localparam int SEL_W = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC);

  logic [NUM_SRC*REG_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]           req;
  logic                         hold;
  logic [NUM_SRC-1:0]           grant;
  logic [REG_WIDTH-1:0]         bus;
  logic                         bus_valid;
  logic [SEL_W-1:0]             bus_src;
  logic                         conflict;
  logic [CNT_WIDTH-1:0]         conflict_cnt;

  modport master (
    output src_data, req, hold,
    input  grant, bus, bus_valid, bus_src, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, req, hold,
    output grant, bus, bus_valid, bus_src, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered N-way bus arbiter/mux with fixed-priority or round-robin selection.
// Macro BUS_ARBITER_MUX_CONFLICT_CNT_EN builds the saturating conflict counter; otherwise it reads 0.
module bus_arbiter_mux #(
  parameter int REG_WIDTH   = 16,
  parameter int NUM_SRC     = 10,
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_WIDTH   = 8
) (
  input logic              clk,
  input logic              rst,
  bus_arbiter_mux_if.slave bif
);
  localparam int SEL_W = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [REG_WIDTH-1:0] bus_q, bus_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [SEL_W-1:0]     bus_src_q, bus_src_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic                 conflict_q, conflict_d;
  logic                 found;
  logic [SEL_W-1:0]     win;
  int                   idx;

`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    grant_d     = grant_q;
    bus_d       = bus_q;
    bus_valid_d = bus_valid_q;
    bus_src_d   = bus_src_q;
    ptr_d       = ptr_q;
    conflict_d  = conflict_q;
    found       = 1'b0;
    win         = '0;
    idx         = 0;
`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
    cnt_d       = cnt_q;
`endif
    if (!bif.hold) begin
      grant_d     = '0;
      bus_valid_d = 1'b0;
      // Search starts at ptr and wraps; in fixed-priority mode ptr never leaves 0.
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = (int'(ptr_q) + k) % NUM_SRC;
        if (!found && bif.req[idx]) begin
          found = 1'b1;
          win   = SEL_W'(idx);
          bus_d = bif.src_data[idx*REG_WIDTH +: REG_WIDTH];
        end
      end
      if (found) begin
        grant_d[win] = 1'b1;
        bus_src_d    = win;
        bus_valid_d  = 1'b1;
        if (ROUND_ROBIN != 0) begin
          ptr_d = (win == SEL_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
        end
      end
      conflict_d = ($countones(bif.req) > 1);
`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
      if (conflict_d && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= '0;
      bus_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      ptr_q       <= '0;
      conflict_q  <= 1'b0;
`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      grant_q     <= grant_d;
      bus_q       <= bus_d;
      bus_valid_q <= bus_valid_d;
      bus_src_q   <= bus_src_d;
      ptr_q       <= ptr_d;
      conflict_q  <= conflict_d;
`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bif.grant     = grant_q;
  assign bif.bus       = bus_q;
  assign bif.bus_valid = bus_valid_q;
  assign bif.bus_src   = bus_src_q;
  assign bif.conflict  = conflict_q;
`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
  assign bif.conflict_cnt = cnt_q;
`else
  assign bif.conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: fixed-priority, round-robin and 2-bit-counter instances
// driven by one stimulus stream and checked against a behavioural model.
module tb_bus_arbiter_mux;
  localparam int NS = 10;
  localparam int RW = 16;
`ifdef BUS_ARBITER_MUX_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int RR[3] = '{0, 1, 0};
  localparam int CW[3] = '{8, 8, 2};

  logic clk;
  logic rst;
  logic hold;
  logic [NS-1:0]    req;
  logic [NS*RW-1:0] src_data;

  int checks   = 0;
  int failures = 0;

  bus_arbiter_mux_if #(.REG_WIDTH(RW), .NUM_SRC(NS), .CNT_WIDTH(8)) if_fp ();
  bus_arbiter_mux_if #(.REG_WIDTH(RW), .NUM_SRC(NS), .CNT_WIDTH(8)) if_rr ();
  bus_arbiter_mux_if #(.REG_WIDTH(RW), .NUM_SRC(NS), .CNT_WIDTH(2)) if_sat ();

  assign if_fp.src_data  = src_data;
  assign if_fp.req       = req;
  assign if_fp.hold      = hold;
  assign if_rr.src_data  = src_data;
  assign if_rr.req       = req;
  assign if_rr.hold      = hold;
  assign if_sat.src_data = src_data;
  assign if_sat.req      = req;
  assign if_sat.hold     = hold;

  bus_arbiter_mux #(.REG_WIDTH(RW), .NUM_SRC(NS), .ROUND_ROBIN(0), .CNT_WIDTH(8))
    u_fp (.clk(clk), .rst(rst), .bif(if_fp));
  bus_arbiter_mux #(.REG_WIDTH(RW), .NUM_SRC(NS), .ROUND_ROBIN(1), .CNT_WIDTH(8))
    u_rr (.clk(clk), .rst(rst), .bif(if_rr));
  bus_arbiter_mux #(.REG_WIDTH(RW), .NUM_SRC(NS), .ROUND_ROBIN(0), .CNT_WIDTH(2))
    u_sat (.clk(clk), .rst(rst), .bif(if_sat));

  // Observed outputs gathered per instance: 0 = fixed, 1 = round-robin, 2 = 2-bit counter
  logic [RW-1:0] a_bus[3];
  logic [NS-1:0] a_grant[3];
  logic          a_valid[3];
  logic [3:0]    a_src[3];
  logic          a_conf[3];
  logic [7:0]    a_cnt[3];

  assign a_bus[0] = if_fp.bus;   assign a_bus[1] = if_rr.bus;   assign a_bus[2] = if_sat.bus;
  assign a_grant[0] = if_fp.grant; assign a_grant[1] = if_rr.grant; assign a_grant[2] = if_sat.grant;
  assign a_valid[0] = if_fp.bus_valid; assign a_valid[1] = if_rr.bus_valid; assign a_valid[2] = if_sat.bus_valid;
  assign a_src[0] = if_fp.bus_src; assign a_src[1] = if_rr.bus_src; assign a_src[2] = if_sat.bus_src;
  assign a_conf[0] = if_fp.conflict; assign a_conf[1] = if_rr.conflict; assign a_conf[2] = if_sat.conflict;
  assign a_cnt[0] = if_fp.conflict_cnt; assign a_cnt[1] = if_rr.conflict_cnt;
  assign a_cnt[2] = {6'b0, if_sat.conflict_cnt};

  // Reference state per instance
  int            m_ptr[3];
  logic [RW-1:0] m_bus[3];
  int            m_src[3];
  bit            m_valid[3];
  logic [NS-1:0] m_grant[3];
  bit            m_conf[3];
  int            m_cnt[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step_model();
    int n;
    int w;
    int cand;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_ptr[i] = 0; m_bus[i] = '0; m_src[i] = 0; m_valid[i] = 0;
        m_grant[i] = '0; m_conf[i] = 0; m_cnt[i] = 0;
      end else if (!hold) begin
        n = $countones(req);
        if (n > 0) begin
          w = -1;
          for (int k = 0; k < NS; k++) begin
            cand = (m_ptr[i] + k) % NS;
            if (w < 0 && req[cand]) w = cand;
          end
          m_grant[i] = NS'(1) << w;
          m_bus[i]   = src_data[w*RW +: RW];
          m_src[i]   = w;
          m_valid[i] = 1;
          if (RR[i] != 0) m_ptr[i] = (w + 1) % NS;
        end else begin
          m_grant[i] = '0;
          m_valid[i] = 0;
        end
        m_conf[i] = (n > 1);
        if (n > 1 && m_cnt[i] < (1 << CW[i]) - 1) m_cnt[i]++;
      end
    end
  endtask

  task automatic cycle();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [RW-1:0] v);
    src_data[s*RW +: RW] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b1; req = 10'h3FF;
    src_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (a_bus[i] !== 16'h0 || a_valid[i] !== 1'b0 || a_grant[i] !== 10'h0 ||
            a_src[i] !== 4'd0 || a_conf[i] !== 1'b0 || a_cnt[i] !== 8'd0) begin
          failures++;
          $display("FAIL reset inst%0d cyc%0d: bus=%h valid=%b grant=%h src=%0d conf=%b cnt=%0d expected all zero",
                   i, c, a_bus[i], a_valid[i], a_grant[i], a_src[i], a_conf[i], a_cnt[i]);
        end
      end
    end
    rst = 1'b0; hold = 1'b0; req = '0;
  endtask

  task automatic test_fixed_priority();
    set_src(2, 16'h1234); set_src(9, 16'hBEEF);
    req = 10'h204;
    cycle();
    req = '0;
    checks++;
    if (a_bus[0] !== 16'h1234) begin failures++; $display("FAIL fp_bus: got %h expected 1234", a_bus[0]); end
    checks++;
    if (a_src[0] !== 4'd2) begin failures++; $display("FAIL fp_src: got %0d expected 2", a_src[0]); end
    checks++;
    if (a_grant[0] !== 10'h004) begin failures++; $display("FAIL fp_grant: got %h expected 004", a_grant[0]); end
    checks++;
    if (a_valid[0] !== 1'b1 || a_conf[0] !== 1'b1) begin
      failures++; $display("FAIL fp_valid_conf: got valid=%b conf=%b expected 1 1", a_valid[0], a_conf[0]);
    end
    checks++;
    if (a_cnt[0] !== (CNT_EN ? 8'd1 : 8'd0)) begin
      failures++; $display("FAIL fp_cnt: got %0d expected %0d", a_cnt[0], CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_round_robin();
    int exp_src[4] = '{0, 9, 0, 9};
    rst = 1'b1; cycle(); rst = 1'b0;
    set_src(0, 16'h0A0A); set_src(9, 16'h9999);
    req = 10'h201;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (a_src[1] !== 4'(exp_src[c]) || a_grant[1] !== (NS'(1) << exp_src[c])) begin
        failures++;
        $display("FAIL rr_seq cyc%0d: got src=%0d grant=%h expected src=%0d", c, a_src[1], a_grant[1], exp_src[c]);
      end
      checks++;
      if (a_bus[1] !== (exp_src[c] == 0 ? 16'h0A0A : 16'h9999)) begin
        failures++; $display("FAIL rr_bus cyc%0d: got %h", c, a_bus[1]);
      end
    end
    req = '0;
    checks++;
    if (a_cnt[1] !== (CNT_EN ? 8'd4 : 8'd0)) begin
      failures++; $display("FAIL rr_cnt: got %0d expected %0d", a_cnt[1], CNT_EN ? 4 : 0);
    end
  endtask

  task automatic test_idle_hold();
    set_src(5, 16'hA5A5);
    req = 10'h020;
    cycle();
    req = '0;
    set_src(5, 16'h5A5A);
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (a_bus[0] !== 16'hA5A5 || a_src[0] !== 4'd5 || a_valid[0] !== 1'b0 || a_grant[0] !== 10'h0) begin
        failures++;
        $display("FAIL idle cyc%0d: got bus=%h src=%0d valid=%b grant=%h expected a5a5 5 0 000",
                 c, a_bus[0], a_src[0], a_valid[0], a_grant[0]);
      end
    end
  endtask

  task automatic test_hold_freeze();
    rst = 1'b1; cycle(); rst = 1'b0;
    set_src(0, 16'h0F0F); set_src(1, 16'h1111);
    req = 10'h001;
    cycle();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req = (c % 2 == 0) ? 10'h3FF : 10'h001;
      set_src(0, 16'(16'hC000 + c));
      cycle();
      checks++;
      if (a_grant[1] !== 10'h001 || a_src[1] !== 4'd0 || a_bus[1] !== 16'h0F0F ||
          a_valid[1] !== 1'b1 || a_conf[1] !== 1'b0 || a_cnt[1] !== 8'd0) begin
        failures++;
        $display("FAIL hold cyc%0d: got grant=%h src=%0d bus=%h valid=%b conf=%b cnt=%0d expected 001 0 0f0f 1 0 0",
                 c, a_grant[1], a_src[1], a_bus[1], a_valid[1], a_conf[1], a_cnt[1]);
      end
    end
    hold = 1'b0;
    req = 10'h3FF;
    cycle();
    req = '0;
    checks++;
    if (a_grant[1] !== 10'h002 || a_src[1] !== 4'd1 || a_bus[1] !== 16'h1111) begin
      failures++;
      $display("FAIL hold_release: got grant=%h src=%0d bus=%h expected 002 1 1111", a_grant[1], a_src[1], a_bus[1]);
    end
    checks++;
    if (a_cnt[1] !== (CNT_EN ? 8'd1 : 8'd0)) begin
      failures++; $display("FAIL hold_release_cnt: got %0d expected %0d", a_cnt[1], CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt[6] = '{1, 2, 3, 3, 3, 3};
    rst = 1'b1; cycle(); rst = 1'b0;
    req = 10'h003;
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if (a_cnt[2] !== (CNT_EN ? 8'(exp_cnt[c]) : 8'd0) || a_conf[2] !== 1'b1) begin
        failures++;
        $display("FAIL sat cyc%0d: got cnt=%0d conf=%b expected cnt=%0d conf=1",
                 c, a_cnt[2], a_conf[2], CNT_EN ? exp_cnt[c] : 0);
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      hold = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = NS'(1) << $urandom_range(0, NS - 1);
        default: req = NS'($urandom);
      endcase
      src_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cycle();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (a_bus[i] !== m_bus[i] || a_grant[i] !== m_grant[i] || a_valid[i] !== m_valid[i] ||
            a_src[i] !== 4'(m_src[i]) || a_conf[i] !== m_conf[i] ||
            a_cnt[i] !== (CNT_EN ? 8'(m_cnt[i]) : 8'd0)) begin
          failures++;
          $display("FAIL random inst%0d cyc%0d: got bus=%h grant=%h valid=%b src=%0d conf=%b cnt=%0d expected bus=%h grant=%h valid=%b src=%0d conf=%b cnt=%0d",
                   i, c, a_bus[i], a_grant[i], a_valid[i], a_src[i], a_conf[i], a_cnt[i],
                   m_bus[i], m_grant[i], m_valid[i], m_src[i], m_conf[i], CNT_EN ? m_cnt[i] : 0);
        end
      end
    end
    rst = 1'b0; hold = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req = '0; src_data = '0;
    #2;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_idle_hold();
    test_hold_freeze();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
